// File: rtl/lsu_pkg.sv
// Shared definitions for the nano_rv32i load/store unit: funct3 codes,
// FSM state encoding, response error codes and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > F3_SW;
    return (f3 == 3'd3) || (f3[2:1] == 2'b11);
  endfunction

  // Only meaningful for legal funct3: bits [1:0] encode the access size.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_if_if.sv
// Memory-side bus between the LSU (master) and data memory (slave).
// Handshake: mem_req_o is held with all address-phase signals stable until the
// cycle mem_gnt_i is high; mem_rvalid_i qualifies mem_rdata_i for one cycle.
interface lsu_bus_if_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables / data replication and
// load lane extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Size comes from funct3[1:0] so loads also present the lanes they touch.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10: be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  always_comb begin
    rdata_o = 32'h0;
    case (funct3_i)
      F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   rdata_o = rword_i;
      F3_LBU:  rdata_o = {24'h0, byte_sel};
      F3_LHU:  rdata_o = {16'h0, half_sel};
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit: accepts one core request at a time, runs it over the
// handshaked memory bus with a bounded stall budget, returns a one-cycle response.
module lsu_bus_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        err_o,
  lsu_bus_if_if.master      mem,
  output lsu_state_e        dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]        be_w;
  logic [31:0]       wdata_w;
  logic [31:0]       rdata_w;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  lsu_lane_align u_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rword_i   (mem.mem_rdata_i),
    .be_o      (be_w),
    .wdata_o   (wdata_w),
    .rdata_o   (rdata_w)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= ERR_OK;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Saturating count: a grant landing on the last budget cycle still leaves
  // WAIT_R at the limit, so the first silent WAIT_R cycle times out.
  always_comb begin
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (cnt_inc == CNT_MAX);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = funct3_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          rdata_d  = 32'h0;
          cnt_d    = '0;
          if (f3_illegal(req_we_i, funct3_i)) begin
            err_d   = ERR_ILLEGAL;
            state_d = ST_RESP;
          end else if (f3_misaligned(funct3_i, addr_i[1:0])) begin
            err_d   = ERR_MISALIGN;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        if (mem.mem_gnt_i) begin
          state_d = we_q ? ST_RESP : ST_WAIT_R;
        end else if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_inc;
        if (mem.mem_rvalid_i) begin
          rdata_d = rdata_w;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = (state_q == ST_IDLE);
    resp_valid_o    = (state_q == ST_RESP);
    rdata_o         = resp_valid_o ? rdata_q : 32'h0;
    err_o           = resp_valid_o ? err_q : ERR_OK;
    mem.mem_req_o   = (state_q == ST_REQ);
    mem.mem_we_o    = mem.mem_req_o & we_q;
    mem.mem_be_o    = mem.mem_req_o ? be_w : 4'b0000;
    mem.mem_addr_o  = mem.mem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem.mem_wdata_o = mem.mem_req_o ? wdata_w : 32'h0;
    dbg_state_o     = state_q;
  end

endmodule
